reg_wr_arbiter: RTL

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

---
 rtl/reg_wr_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin arbiter funnelling NPORT statistics writers onto one register-table write port.
// Optional feature macro ARB_ACK_TIMEOUT_EN aborts a transfer after TIMEOUT_CYCLES busy cycles without reg_ack.
module reg_wr_arbiter #(
    parameter int unsigned NPORT          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned DELAY          = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT*7-1:0]  req_addr,
    input  logic [NPORT*16-1:0] req_din,
    output logic [NPORT-1:0]    ack,
    output logic [8:0]          reg_addr,
    output logic [15:0]         reg_din,
    output logic                reg_req,
    input  logic                reg_ack,
    output logic                timeout_pulse,
    output logic [7:0]          timeout_cnt
);
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 2;

    // Elaboration-time parameter sanity check; DELAY only models update delay and has no hardware.
    if (NPORT < 2 || NPORT > 4 || TIMEOUT_CYCLES > 255 || DELAY > 255) begin : g_param_check
        $error("reg_wr_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_win;
    logic            r_reg_req;
    logic [8:0]      r_reg_addr;
    logic [DW-1:0]   r_reg_din;
    logic [NPORT-1:0] r_ack;

    logic [IW-1:0]   w_rr_nxt;
    logic [IW-1:0]   w_win_nxt;
    logic            w_reg_req_nxt;
    logic [8:0]      w_reg_addr_nxt;
    logic [DW-1:0]   w_reg_din_nxt;
    logic [NPORT-1:0] w_ack_nxt;

    logic            w_found;
    logic [IW-1:0]   w_grant;
    logic [AW-1:0]   w_grant_addr;
    logic [DW-1:0]   w_grant_din;
    logic            w_win_req;
    logic [NPORT-1:0] w_win_onehot;
    logic            w_tmo;
    logic            w_done;

    // Round-robin search: first pending requester at or above r_rr_ptr, wrapping modulo NPORT.
    always_comb begin
        w_found      = 1'b0;
        w_grant      = '0;
        w_grant_addr = '0;
        w_grant_din  = '0;
        for (int unsigned off = 0; off < NPORT; off++) begin
            for (int unsigned i = 0; i < NPORT; i++) begin
                if (!w_found && req[i] && (((32'(r_rr_ptr) + 32'(off)) % NPORT) == 32'(i))) begin
                    w_found      = 1'b1;
                    w_grant      = IW'(i);
                    w_grant_addr = req_addr[i*AW +: AW];
                    w_grant_din  = req_din[i*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        w_win_req    = 1'b0;
        w_win_onehot = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (IW'(i) == r_win) begin
                w_win_req       = req[i];
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    assign w_done = (r_state == S_BUSY) && (reg_ack || w_tmo);

`ifdef ARB_ACK_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       r_tpulse;
    logic [7:0] r_tcnt;

    // A reg_ack on the limit cycle wins over the timeout.
    assign w_tmo = (r_state == S_BUSY) && !reg_ack &&
                   ((9'(r_wait) + 9'd1) >= 9'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait   <= '0;
            r_tpulse <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            r_tpulse <= w_tmo;
            if (r_state == S_IDLE && w_found) begin
                r_wait <= '0;
            end else if (r_state == S_BUSY && !reg_ack) begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_tmo && r_tcnt != 8'hFF) begin
                r_tcnt <= r_tcnt + 8'd1;
            end
        end
    end

    assign timeout_pulse = r_tpulse;
    assign timeout_cnt   = r_tcnt;
`else
    assign w_tmo         = 1'b0;
    assign timeout_pulse = 1'b0;
    assign timeout_cnt   = 8'd0;
`endif

    // State register plus registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_win      <= '0;
            r_reg_req  <= 1'b0;
            r_reg_addr <= '0;
            r_reg_din  <= '0;
            r_ack      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_win      <= w_win_nxt;
            r_reg_req  <= w_reg_req_nxt;
            r_reg_addr <= w_reg_addr_nxt;
            r_reg_din  <= w_reg_din_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_found)    w_state_nxt = S_BUSY;
            S_BUSY:    if (w_done)     w_state_nxt = S_RELEASE;
            S_RELEASE: if (!w_win_req) w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rr_nxt       = r_rr_ptr;
        w_win_nxt      = r_win;
        w_reg_req_nxt  = r_reg_req;
        w_reg_addr_nxt = r_reg_addr;
        w_reg_din_nxt  = r_reg_din;
        w_ack_nxt      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_win_nxt      = w_grant;
                    w_rr_nxt       = (w_grant == IW'(NPORT - 1)) ? '0 : w_grant + IW'(1);
                    w_reg_req_nxt  = 1'b1;
                    w_reg_addr_nxt = {w_grant, w_grant_addr};
                    w_reg_din_nxt  = w_grant_din;
                end
            end
            S_BUSY: begin
                if (w_done) begin
                    w_reg_req_nxt = 1'b0;
                    w_ack_nxt     = w_win_onehot;
                end
            end
            default: begin
            end
        endcase
    end

    assign ack      = r_ack;
    assign reg_addr = r_reg_addr;
    assign reg_din  = r_reg_din;
    assign reg_req  = r_reg_req;

endmodule
